proc_control_unit: RTL and testbench
====================================

Name: proc_control_unit

Overview:
- Multi-cycle control unit for the 16-bit CECS 301 processor.
- Sequences fetch, decode and execute of one instruction per single-step pulse.
- Drives PC, IR, memory, register-file and ALU control strobes.
- Exposes state and a retired-instruction counter so the board display mux can show them.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- Step  in  1  one-cycle step pulse from debouncer
- IR  in  16  instruction register contents; fields op=IR[15:12], W=IR[11:8], R=IR[7:4], S=IR[3:0]
- Z  in  1  zero flag of register R value, from datapath
- pc_inc  out  1  PC <= PC+1
- pc_ld  out  1  PC <= reg[R]
- ir_ld  out  1  IR <= mem data
- mem_rd  out  1  memory read
- mem_we  out  1  memory write
- addr_sel  out  1  memory address: 0=PC, 1=reg[R]
- rf_we  out  1  register-file write to W
- wb_sel  out  2  write-back source: 0=ALU, 1=memory, 2=immediate
- alu_op  out  4  ALU function (= op for op<=9, else 0)
- W_Adr, R_Adr, S_Adr  out  4 each  register addresses, straight from IR fields
- imm  out  8  {R,S} zero-extended by datapath
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- state  out  4  current state encoding
- icount  out  CNT_W  retired instructions

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, EX_ALU=3, EX_LD=4, WB_LD=5, EX_ST=6, EX_LDI=7, EX_JMP=8, EX_JZ=9, HALT=10.
- State register and icount are registered.
- All strobes are Moore decodes of state plus IR fields.
- A strobe not listed for a state is 0.
- Reset (any cycle, including mid-instruction): state=IDLE, icount=0, all strobes 0.
- Reset aborts any in-flight operation. No partial write is issued in the cycle after reset.
- IDLE: no strobes. If Step=1, go to FETCH; else stay.
- FETCH: mem_rd=1, addr_sel=0, ir_ld=1, pc_inc=1. Next state DECODE.
- DECODE: no strobes. Next state by op:
  - op 0-9 (ADD, SUB, AND, OR, XOR, NOT, INC, DEC, SHL, SHR): EX_ALU
  - A (LD): EX_LD
  - B (ST): EX_ST
  - C (LDI): EX_LDI
  - D (JMP): EX_JMP
  - E (JZ): EX_JZ
  - F: HALT
- EX_ALU: rf_we=1, wb_sel=0, alu_op=op. Next state IDLE.
- EX_LD: mem_rd=1, addr_sel=1. Next state WB_LD.
- WB_LD: mem_rd=1, addr_sel=1, rf_we=1, wb_sel=1. Next state IDLE.
- EX_ST: mem_we=1, addr_sel=1; data is reg[S]. Next state IDLE.
- EX_LDI: rf_we=1, wb_sel=2. Next state IDLE.
- EX_JMP: pc_ld=1. Next state IDLE.
- EX_JZ: pc_ld=Z, with Z sampled this cycle. Next state IDLE.
- HALT: halted=1, no strobes. Step is ignored; only rst exits.
- icount increments by 1 on every transition into IDLE from an execute/writeback state, and on entry to HALT. It wraps from all-ones to 0.
- Step while busy or halted is ignored and not queued.
- Step held high continuously starts a new instruction on each IDLE cycle.
- Latency, counting the cycle Step is sampled in IDLE as n:
  - ALU, LDI, JMP, JZ, ST: back in IDLE at n+4.
  - LD: back in IDLE at n+5.
- Simultaneous rst and Step: rst wins; state=IDLE, and the step is lost.

Test Plan:
- Reset: hold rst 3 cycles with Step=1 → state=0, all strobes 0, icount=0, busy=0. After release with Step=0 → stays IDLE.
- ADD, IR=0x0123, Step pulse at cycle n:
  - n+1: FETCH, mem_rd=ir_ld=pc_inc=1.
  - n+3: rf_we=1, alu_op=0, W_Adr=1, R_Adr=2, S_Adr=3.
  - n+4: IDLE, icount=1.
- LD IR=0xA450 → rf_we=1 with wb_sel=1 only at n+4, addr_sel=1 at n+3 and n+4, IDLE at n+5. ST IR=0xB050 → mem_we=1 only at n+3.
- JZ IR=0xE030: Z=1 → pc_ld=1 at n+3; Z=0 → pc_ld=0. JMP IR=0xD030 → pc_ld=1. LDI IR=0xC7AB → imm=0xAB, wb_sel=2.
- Step at n+2 (DECODE) → ignored, IDLE at n+4, icount +1 only. IR=0xF000 → HALT; further Steps leave halted=1; rst → IDLE.
- Assert rst during WB_LD → next cycle IDLE, rf_we=0, icount=0. With icount preloaded to 0xFFFF via 65535 steps (or force), one more instruction → 0x0000.

Source files
------------

// File: rtl/proc_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit CECS 301 processor.
// A Step pulse in IDLE runs one instruction; every strobe is a Moore decode of state and IR.
module proc_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Step,
  input  logic [15:0]      IR,
  input  logic             Z,
  output logic             pc_inc,
  output logic             pc_ld,
  output logic             ir_ld,
  output logic             mem_rd,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic [3:0]       alu_op,
  output logic [3:0]       W_Adr,
  output logic [3:0]       R_Adr,
  output logic [3:0]       S_Adr,
  output logic [7:0]       imm,
  output logic             busy,
  output logic             halted,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] icount
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EX_ALU = 4'd3,
    EX_LD  = 4'd4,
    WB_LD  = 4'd5,
    EX_ST  = 4'd6,
    EX_LDI = 4'd7,
    EX_JMP = 4'd8,
    EX_JZ  = 4'd9,
    HALT   = 4'd10
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] icount_reg;
  logic             retire;
  logic [3:0]       op;

  assign op = IR[15:12];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      icount_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire)
        icount_reg <= icount_reg + CNT_W'(1);
    end
  end

  // retire marks the last cycle of an instruction, including the one that enters HALT
  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    case (state_reg)
      IDLE:   if (Step) state_next = FETCH;
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (op)
          4'hA:    state_next = EX_LD;
          4'hB:    state_next = EX_ST;
          4'hC:    state_next = EX_LDI;
          4'hD:    state_next = EX_JMP;
          4'hE:    state_next = EX_JZ;
          4'hF: begin
            state_next = HALT;
            retire     = 1'b1;
          end
          default: state_next = EX_ALU;
        endcase
      end
      EX_LD:  state_next = WB_LD;
      EX_ALU, WB_LD, EX_ST, EX_LDI, EX_JMP, EX_JZ: begin
        state_next = IDLE;
        retire     = 1'b1;
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pc_inc   = 1'b0;
    pc_ld    = 1'b0;
    ir_ld    = 1'b0;
    mem_rd   = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 2'd0;
    alu_op   = 4'd0;
    case (state_reg)
      FETCH: begin
        mem_rd = 1'b1;
        ir_ld  = 1'b1;
        pc_inc = 1'b1;
      end
      EX_ALU: begin
        rf_we  = 1'b1;
        alu_op = (op <= 4'd9) ? op : 4'd0;
      end
      EX_LD: begin
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
      end
      WB_LD: begin
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
        rf_we    = 1'b1;
        wb_sel   = 2'd1;
      end
      EX_ST: begin
        mem_we   = 1'b1;
        addr_sel = 1'b1;
      end
      EX_LDI: begin
        rf_we  = 1'b1;
        wb_sel = 2'd2;
      end
      EX_JMP: pc_ld = 1'b1;
      EX_JZ:  pc_ld = Z;
      default: ;
    endcase
  end

  assign W_Adr  = IR[11:8];
  assign R_Adr  = IR[7:4];
  assign S_Adr  = IR[3:0];
  assign imm    = IR[7:0];
  assign busy   = (state_reg != IDLE) && (state_reg != HALT);
  assign halted = (state_reg == HALT);
  assign state  = state_reg;
  assign icount = icount_reg;

endmodule

// File: tb/tb_proc_control_unit.sv
// Scoreboard bench for proc_control_unit: stimulus queues expected per-cycle outputs,
// a negedge monitor compares them; a 3-bit-counter twin exercises icount wrap.
module tb_proc_control_unit;

  logic        clk = 1'b0;
  logic        rst, Step, Z;
  logic [15:0] IR;

  logic        pc_inc, pc_ld, ir_ld, mem_rd, mem_we, addr_sel, rf_we, busy, halted;
  logic [1:0]  wb_sel;
  logic [3:0]  alu_op, W_Adr, R_Adr, S_Adr, state;
  logic [7:0]  imm;
  logic [15:0] icount;

  logic        s_pc_inc, s_pc_ld, s_ir_ld, s_mem_rd, s_mem_we, s_addr_sel, s_rf_we, s_busy, s_halted;
  logic [1:0]  s_wb_sel;
  logic [3:0]  s_alu_op, s_W_Adr, s_R_Adr, s_S_Adr, s_state;
  logic [7:0]  s_imm;
  logic [2:0]  s_icount;

  proc_control_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .Step(Step), .IR(IR), .Z(Z),
    .pc_inc(pc_inc), .pc_ld(pc_ld), .ir_ld(ir_ld), .mem_rd(mem_rd), .mem_we(mem_we),
    .addr_sel(addr_sel), .rf_we(rf_we), .wb_sel(wb_sel), .alu_op(alu_op),
    .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr), .imm(imm),
    .busy(busy), .halted(halted), .state(state), .icount(icount)
  );

  proc_control_unit #(.CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .Step(Step), .IR(IR), .Z(Z),
    .pc_inc(s_pc_inc), .pc_ld(s_pc_ld), .ir_ld(s_ir_ld), .mem_rd(s_mem_rd), .mem_we(s_mem_we),
    .addr_sel(s_addr_sel), .rf_we(s_rf_we), .wb_sel(s_wb_sel), .alu_op(s_alu_op),
    .W_Adr(s_W_Adr), .R_Adr(s_R_Adr), .S_Adr(s_S_Adr), .imm(s_imm),
    .busy(s_busy), .halted(s_halted), .state(s_state), .icount(s_icount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          kind;     // 0: state/strobes/icount, 1: IR field outputs
    logic [3:0]  st;
    logic [14:0] vec;
    logic [15:0] cnt;
    logic [19:0] fld;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // {pc_inc,pc_ld,ir_ld,mem_rd,mem_we,addr_sel,rf_we,wb_sel,alu_op,busy,halted}
  function automatic logic [14:0] v(input logic pi, pl, il, mr, mw, as_, rw,
                                    input logic [1:0] wb, input logic [3:0] alu,
                                    input logic b, h);
    return {pi, pl, il, mr, mw, as_, rw, wb, alu, b, h};
  endfunction

  logic [14:0] V_IDLE, V_FETCH, V_DEC, V_HALT;
  logic [15:0] exp_icnt;

  task automatic push(input int c, input logic [3:0] st, input logic [14:0] vec, input logic [15:0] cnt);
    exp_t e;
    e.cyc = c; e.kind = 1'b0; e.st = st; e.vec = vec; e.cnt = cnt; e.fld = '0;
    sb.push_back(e);
  endtask

  task automatic push_f(input int c, input logic [19:0] fld);
    exp_t e;
    e.cyc = c; e.kind = 1'b1; e.st = '0; e.vec = '0; e.cnt = '0; e.fld = fld;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req, input int c);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, c, act, req);
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        if (sb[i].kind) begin
          check("fields", {W_Adr, R_Adr, S_Adr, imm}, {12'd0, sb[i].fld}, cyc);
        end else begin
          check("state", {28'd0, state}, {28'd0, sb[i].st}, cyc);
          check("strobes", {17'd0, pc_inc, pc_ld, ir_ld, mem_rd, mem_we, addr_sel, rf_we,
                            wb_sel, alu_op, busy, halted}, {17'd0, sb[i].vec}, cyc);
          check("icount", {16'd0, icount}, {16'd0, sb[i].cnt}, cyc);
          check("icount_wrap3", {29'd0, s_icount}, {29'd0, sb[i].cnt[2:0]}, cyc);
        end
        $display("cyc %0d: kind=%0d state=%0d icount=0x%0h", cyc, sb[i].kind, state, icount);
        sb.delete(i);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One instruction from IDLE; ex1/st1 is the first execute cycle, ex2/st2 the LD writeback.
  task automatic run_instr(input logic [15:0] ir, input logic z,
                           input logic [3:0] st1, input logic [14:0] ex1,
                           input bit two, input logic [3:0] st2, input logic [14:0] ex2,
                           input bit halt, input bit chk_f, input logic [19:0] fld,
                           input bit extra_step);
    int p;
    p = cyc;
    IR = ir; Z = z; Step = 1'b1;
    push(p + 1, 4'd1, V_FETCH, exp_icnt);
    push(p + 2, 4'd2, V_DEC, exp_icnt);
    if (halt) begin
      exp_icnt = exp_icnt + 16'd1;
      push(p + 3, 4'd10, V_HALT, exp_icnt);
    end else begin
      push(p + 3, st1, ex1, exp_icnt);
      if (chk_f) push_f(p + 3, fld);
      if (two) push(p + 4, st2, ex2, exp_icnt);
      exp_icnt = exp_icnt + 16'd1;
      push(two ? p + 5 : p + 4, 4'd0, V_IDLE, exp_icnt);
    end
    tick; Step = 1'b0;
    tick; if (extra_step) Step = 1'b1;
    tick; Step = 1'b0;
    if (!halt) begin
      tick;
      if (two) tick;
    end
  endtask

  initial begin
    int p;
    V_IDLE  = v(0,0,0,0,0,0,0,2'd0,4'd0,0,0);
    V_FETCH = v(1,0,1,1,0,0,0,2'd0,4'd0,1,0);
    V_DEC   = v(0,0,0,0,0,0,0,2'd0,4'd0,1,0);
    V_HALT  = v(0,0,0,0,0,0,0,2'd0,4'd0,0,1);
    exp_icnt = 16'd0;

    // reset held 3 cycles with Step high, then idle with Step low
    rst = 1'b1; Step = 1'b1; IR = 16'h0000; Z = 1'b0;
    for (int i = 1; i <= 3; i++) push(i, 4'd0, V_IDLE, 16'd0);
    tick; tick; tick;
    rst = 1'b0; Step = 1'b0;
    push(cyc + 1, 4'd0, V_IDLE, 16'd0);
    push(cyc + 2, 4'd0, V_IDLE, 16'd0);
    tick; tick;

    // ADD, XOR, SHR
    run_instr(16'h0123, 0, 4'd3, v(0,0,0,0,0,0,1,2'd0,4'd0,1,0), 0, 0, 0, 0, 1, 20'h12323, 0);
    run_instr(16'h4ABC, 0, 4'd3, v(0,0,0,0,0,0,1,2'd0,4'd4,1,0), 0, 0, 0, 0, 0, 0, 0);
    run_instr(16'h9111, 0, 4'd3, v(0,0,0,0,0,0,1,2'd0,4'd9,1,0), 0, 0, 0, 0, 0, 0, 0);
    // LD: EX_LD then WB_LD
    run_instr(16'hA450, 0, 4'd4, v(0,0,0,1,0,1,0,2'd0,4'd0,1,0),
              1, 4'd5, v(0,0,0,1,0,1,1,2'd1,4'd0,1,0), 0, 0, 0, 0);
    // ST
    run_instr(16'hB050, 0, 4'd6, v(0,0,0,0,1,1,0,2'd0,4'd0,1,0), 0, 0, 0, 0, 0, 0, 0);
    // JZ taken / not taken, JMP
    run_instr(16'hE030, 1, 4'd9, v(0,1,0,0,0,0,0,2'd0,4'd0,1,0), 0, 0, 0, 0, 0, 0, 0);
    run_instr(16'hE030, 0, 4'd9, v(0,0,0,0,0,0,0,2'd0,4'd0,1,0), 0, 0, 0, 0, 0, 0, 0);
    run_instr(16'hD030, 0, 4'd8, v(0,1,0,0,0,0,0,2'd0,4'd0,1,0), 0, 0, 0, 0, 0, 0, 0);
    // LDI with immediate fields
    run_instr(16'hC7AB, 0, 4'd7, v(0,0,0,0,0,0,1,2'd2,4'd0,1,0), 0, 0, 0, 0, 1, 20'h7AB_AB, 0);
    // Step during DECODE is ignored; stays idle afterwards
    run_instr(16'h0123, 0, 4'd3, v(0,0,0,0,0,0,1,2'd0,4'd0,1,0), 0, 0, 0, 0, 0, 0, 1);
    push(cyc + 1, 4'd0, V_IDLE, exp_icnt);
    tick;

    // HALT: Steps ignored, rst together with Step returns to IDLE
    run_instr(16'hF000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    Step = 1'b1;
    for (int i = 1; i <= 3; i++) push(cyc + i, 4'd10, V_HALT, exp_icnt);
    tick; tick; tick;
    rst = 1'b1;
    exp_icnt = 16'd0;
    push(cyc + 1, 4'd0, V_IDLE, exp_icnt);
    tick;
    rst = 1'b0; Step = 1'b0;
    push(cyc + 1, 4'd0, V_IDLE, exp_icnt);
    tick;

    // two instructions then reset during WB_LD
    run_instr(16'h1234, 0, 4'd3, v(0,0,0,0,0,0,1,2'd0,4'd1,1,0), 0, 0, 0, 0, 0, 0, 0);
    run_instr(16'h2345, 0, 4'd3, v(0,0,0,0,0,0,1,2'd0,4'd2,1,0), 0, 0, 0, 0, 0, 0, 0);
    p = cyc;
    IR = 16'hA450; Step = 1'b1;
    push(p + 1, 4'd1, V_FETCH, exp_icnt);
    push(p + 2, 4'd2, V_DEC, exp_icnt);
    push(p + 3, 4'd4, v(0,0,0,1,0,1,0,2'd0,4'd0,1,0), exp_icnt);
    push(p + 4, 4'd5, v(0,0,0,1,0,1,1,2'd1,4'd0,1,0), exp_icnt);
    tick; Step = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    exp_icnt = 16'd0;
    push(p + 5, 4'd0, V_IDLE, exp_icnt);
    tick;
    rst = 1'b0;
    push(p + 6, 4'd0, V_IDLE, exp_icnt);
    tick;

    // one more instruction after the abort
    run_instr(16'h5600, 0, 4'd3, v(0,0,0,0,0,0,1,2'd0,4'd5,1,0), 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
